sha256_block_engine: RTL

//  Iterative SHA-256 compression engine: accepts one 512-bit padded block, runs the message

---
 rtl/sha256_block_engine.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/sha256_block_engine.sv
// Iterative SHA-256 compression engine.
// Accepts one padded 512-bit block, runs UNROLL rounds per clock over a sliding
// 16-word schedule window and returns the 256-bit chaining value. Multi-block
// messages chain through the internal H register when in_first is low.
module sha256_block_engine #(
  parameter int UNROLL    = 1,
  parameter bit USE_CHAIN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_block,
  input  logic         in_first,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_digest,
  output logic         busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_FINAL,
    S_HOLD
  } state_t;

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [6:0] LAST_T = 7'(64 - UNROLL);

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] sml_sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sml_sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                    input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  state_t        state_q, state_d;
  logic [6:0]    t_q, t_d;
  logic          first_q, first_d;
  logic [31:0]   h_q [8];
  logic [31:0]   h_d [8];
  logic [255:0]  digest_q, digest_d;
  logic [31:0]   w_q [16];
  logic [31:0]   w_d [16];
  logic [31:0]   work_q [8];
  logic [31:0]   work_d [8];
  logic [31:0]   base_q [8];
  logic [31:0]   base_d [8];

  logic [31:0]   sched [16+UNROLL];
  logic [31:0]   win_next [16];
  logic [31:0]   rnd_work [8];

  // Extend the window by UNROLL schedule words; later words may depend on earlier new ones.
  always_comb begin
    logic [31:0] ext [16+UNROLL];
    for (int i = 0; i < 16; i++) begin
      ext[i] = w_q[i];
    end
    for (int k = 0; k < UNROLL; k++) begin
      ext[16+k] = sml_sig1(ext[14+k]) + ext[9+k] + sml_sig0(ext[1+k]) + ext[k];
    end
    sched = ext;
    for (int i = 0; i < 16; i++) begin
      win_next[i] = ext[i+UNROLL];
    end
  end

  // Apply UNROLL compression rounds to the working variables in one clock.
  always_comb begin
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    a = work_q[0]; b = work_q[1]; c = work_q[2]; d = work_q[3];
    e = work_q[4]; f = work_q[5]; g = work_q[6]; h = work_q[7];
    for (int k = 0; k < UNROLL; k++) begin
      t1 = h + big_sig1(e) + ch(e, f, g) + K_ROM[t_q[5:0] + 6'(k)] + sched[k];
      t2 = big_sig0(a) + maj(a, b, c);
      h = g;
      g = f;
      f = e;
      e = d + t1;
      d = c;
      c = b;
      b = a;
      a = t1 + t2;
    end
    rnd_work[0] = a; rnd_work[1] = b; rnd_work[2] = c; rnd_work[3] = d;
    rnd_work[4] = e; rnd_work[5] = f; rnd_work[6] = g; rnd_work[7] = h;
  end

  // Next-state and datapath selection for the IDLE/LOAD/ROUND/FINAL/HOLD sequence.
  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    first_d  = first_q;
    h_d      = h_q;
    digest_d = digest_q;
    w_d      = w_q;
    work_d   = work_q;
    base_d   = base_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          for (int i = 0; i < 16; i++) begin
            w_d[i] = in_block[511-32*i -: 32];
          end
          first_d = in_first;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        for (int i = 0; i < 8; i++) begin
          base_d[i] = (first_q || !USE_CHAIN) ? IV[i] : h_q[i];
          work_d[i] = base_d[i];
        end
        t_d     = '0;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        work_d = rnd_work;
        w_d    = win_next;
        t_d    = t_q + 7'(UNROLL);
        if (t_q == LAST_T) begin
          state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        for (int i = 0; i < 8; i++) begin
          h_d[i] = base_q[i] + work_q[i];
          digest_d[255-32*i -: 32] = h_d[i];
        end
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state, chain register and digest; reset aborts any block in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      t_q      <= '0;
      first_q  <= 1'b1;
      digest_q <= '0;
      for (int i = 0; i < 8; i++) begin
        h_q[i] <= IV[i];
      end
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      first_q  <= first_d;
      digest_q <= digest_d;
      h_q      <= h_d;
    end
  end

  // Schedule window and working variables are pure datapath and need no reset.
  always_ff @(posedge clk) begin
    w_q    <= w_d;
    work_q <= work_d;
    base_q <= base_d;
  end

  assign in_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign out_valid  = (state_q == S_HOLD);
  assign out_digest = digest_q;

endmodule
